reg_counter_bank: RTL and testbench

Parametrised bank of up-/down-counting registers, the multi-channel successor to the single 8-bit load/clear/increment register. Each channel holds a WIDTH-bit value with a programmable limit. Wrap or saturate behaviour is selected at elaboration. A shared load bus with channel select serves the processor's address, loop and index counters. Boundary events produce terminal-count flags and a one-cycle event pulse.

---
 rtl/reg_bank_pkg.sv | 31 +++
 rtl/reg_counter_chan.sv | 111 +++++++++++
 rtl/reg_counter_bank.sv | 80 ++++++++
 tb/tb_reg_counter_bank.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the counter bank:
//   MODE_WRAP / MODE_SAT : values of the SATURATE parameter
//   clog2()              : ceiling log2, at least 1, used to size the sel port
// -----------------------------------------------------------------------------
package reg_bank_pkg;

   localparam int MODE_WRAP = 32'sd0;
   localparam int MODE_SAT  = 32'sd1;

   // Ceiling log2, never less than 1 so a select port always has a bit.
   function automatic int clog2(input int n);
      int r;
      r = 32'sd0;
      for (int k = 0; k < 31; k++) begin
         if ((32'sd1 << k) < n) begin
            r = k + 32'sd1;
         end else begin
            r = r;
         end
      end
      if (r < 32'sd1) begin
         r = 32'sd1;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_counter_chan.sv
// -----------------------------------------------------------------------------
// reg_counter_chan
// One channel of the counter bank: value register, limit register, next-state
// logic and the registered event flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : local value load strobe (already decoded from sel)
//   i_lim_load   : local limit load strobe (already decoded from sel)
//   i_datain     : shared load data
//   i_inc/i_dec  : step requests
//   i_clr        : clear value
//   o_value      : registered value
//   o_tc         : value >= limit
//   o_zero       : value == 0
//   o_evt        : one-cycle pulse after a wrap/saturate event
// -----------------------------------------------------------------------------
module reg_counter_chan
   import reg_bank_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_lim_load,
   input  logic [WIDTH-1:0] i_datain,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_value,
   output logic             o_tc,
   output logic             o_zero,
   output logic             o_evt
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_value;
   logic [WIDTH-1:0] r_limit;
   logic             r_evt;

   logic [WIDTH-1:0] w_value_nxt;
   logic [WIDTH-1:0] w_limit_nxt;
   logic             w_evt_nxt;
   logic             w_at_top;
   logic             w_at_bottom;

   // >= so that a value loaded above the limit still wraps/saturates.
   assign w_at_top    = (r_value >= r_limit);
   assign w_at_bottom = (r_value == ZERO);

   // Value next-state: clr > load > inc/dec; steps compare against the old limit.
   always_comb begin
      w_value_nxt = r_value;
      w_evt_nxt   = 1'b0;
      if (i_clr) begin
         w_value_nxt = ZERO;
      end else if (i_load) begin
         w_value_nxt = i_datain;
      end else if (i_inc && !i_dec) begin
         if (w_at_top) begin
            w_evt_nxt   = 1'b1;
            w_value_nxt = (SATURATE == MODE_SAT) ? r_value : ZERO;
         end else begin
            w_value_nxt = r_value + ONE;
         end
      end else if (i_dec && !i_inc) begin
         if (w_at_bottom) begin
            w_evt_nxt   = 1'b1;
            w_value_nxt = (SATURATE == MODE_SAT) ? r_value : r_limit;
         end else begin
            w_value_nxt = r_value - ONE;
         end
      end else begin
         // Idle, or inc and dec together: hold.
         w_value_nxt = r_value;
      end
   end

   // Limit next-state: independent of the value path.
   always_comb begin
      w_limit_nxt = r_limit;
      if (i_lim_load) begin
         w_limit_nxt = i_datain;
      end else begin
         w_limit_nxt = r_limit;
      end
   end

   // Value, limit and event registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= ZERO;
         r_limit <= ONES;
         r_evt   <= 1'b0;
      end else begin
         r_value <= w_value_nxt;
         r_limit <= w_limit_nxt;
         r_evt   <= w_evt_nxt;
      end
   end

   assign o_value = r_value;
   assign o_tc    = w_at_top;
   assign o_zero  = w_at_bottom;
   assign o_evt   = r_evt;

endmodule

// File: rtl/reg_counter_bank.sv
// -----------------------------------------------------------------------------
// reg_counter_bank
// Bank of CHANNELS up/down counters with programmable limits and a shared
// load bus addressed by sel.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (clears all)
//   sel                : channel addressed by write_en / lim_write_en
//   write_en           : load datain into value[sel]
//   lim_write_en       : load datain into limit[sel]
//   datain             : shared load data
//   inc, dec, clr      : per-channel requests
//   dataout            : packed values, channel i at [i*WIDTH +: WIDTH]
//   tc, zero, evt      : per-channel terminal count, zero and event flags
// -----------------------------------------------------------------------------
module reg_counter_bank
   import reg_bank_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int SATURATE = 0,
   localparam int CW       = clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CW-1:0]             sel,
   input  logic                      write_en,
   input  logic                      lim_write_en,
   input  logic [WIDTH-1:0]          datain,
   input  logic [CHANNELS-1:0]       inc,
   input  logic [CHANNELS-1:0]       dec,
   input  logic [CHANNELS-1:0]       clr,
   output logic [CHANNELS*WIDTH-1:0] dataout,
   output logic [CHANNELS-1:0]       tc,
   output logic [CHANNELS-1:0]       zero,
   output logic [CHANNELS-1:0]       evt
);

   logic                w_sel_valid;
   logic [CHANNELS-1:0] w_load;
   logic [CHANNELS-1:0] w_lim_load;

   // Out-of-range selects (non power-of-two CHANNELS) address nothing.
   assign w_sel_valid = (int'(sel) < CHANNELS);

   // Decode sel into per-channel value and limit load strobes.
   always_comb begin
      w_load     = {CHANNELS{1'b0}};
      w_lim_load = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_sel_valid && (int'(sel) == i)) begin
            w_load[i]     = write_en;
            w_lim_load[i] = lim_write_en;
         end else begin
            w_load[i]     = 1'b0;
            w_lim_load[i] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      reg_counter_chan #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .i_load     (w_load[g]),
         .i_lim_load (w_lim_load[g]),
         .i_datain   (datain),
         .i_inc      (inc[g]),
         .i_dec      (dec[g]),
         .i_clr      (clr[g]),
         .o_value    (dataout[g*WIDTH +: WIDTH]),
         .o_tc       (tc[g]),
         .o_zero     (zero[g]),
         .o_evt      (evt[g])
      );
   end

endmodule

// File: tb/tb_reg_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_counter_bank
// Directed bench: two instances share one stimulus bus, one in wrap mode and
// one in saturate mode. Each scenario task drives stimulus and checks inline.
// -----------------------------------------------------------------------------
module tb_reg_counter_bank;

   logic        clk;
   logic        reset;
   logic [1:0]  sel;
   logic        write_en;
   logic        lim_write_en;
   logic [7:0]  datain;
   logic [3:0]  inc;
   logic [3:0]  dec;
   logic [3:0]  clr;

   logic [31:0] dout_w;
   logic [3:0]  tc_w;
   logic [3:0]  zero_w;
   logic [3:0]  evt_w;
   logic [31:0] dout_s;
   logic [3:0]  tc_s;
   logic [3:0]  zero_s;
   logic [3:0]  evt_s;

   int n_checks;
   int n_fail;

   reg_counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) dut_w (
      .clk(clk), .reset(reset), .sel(sel), .write_en(write_en),
      .lim_write_en(lim_write_en), .datain(datain), .inc(inc), .dec(dec),
      .clr(clr), .dataout(dout_w), .tc(tc_w), .zero(zero_w), .evt(evt_w)
   );

   reg_counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) dut_s (
      .clk(clk), .reset(reset), .sel(sel), .write_en(write_en),
      .lim_write_en(lim_write_en), .datain(datain), .inc(inc), .dec(dec),
      .clr(clr), .dataout(dout_s), .tc(tc_s), .zero(zero_s), .evt(evt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ch(input logic [31:0] d, input int i);
      return d[i*8 +: 8];
   endfunction

   task automatic idle();
      reset = 1'b0; sel = 2'd0; write_en = 1'b0; lim_write_en = 1'b0;
      datain = 8'h00; inc = 4'h0; dec = 4'h0; clr = 4'h0;
   endtask

   // One clock: inputs already applied, outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (dout_w !== 32'h0 || dout_s !== 32'h0) begin
         n_fail++; $display("FAIL reset_dataout got %h/%h want 0", dout_w, dout_s);
      end
      n_checks++;
      if (tc_w !== 4'h0 || zero_w !== 4'hF || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL reset_flags tc=%b zero=%b evt=%b want 0000/1111/0000", tc_w, zero_w, evt_w);
      end
   endtask

   task automatic test_inc();
      do_reset();
      inc = 4'b0001;
      for (int k = 0; k < 3; k++) tick();
      idle();
      n_checks++;
      if (dout_w !== 32'h0000_0003) begin
         n_fail++; $display("FAIL inc3_dataout got %h want 00000003", dout_w);
      end
      n_checks++;
      if (zero_w !== 4'b1110 || tc_w !== 4'b0000 || evt_w !== 4'b0000) begin
         n_fail++; $display("FAIL inc3_flags zero=%b tc=%b evt=%b want 1110/0000/0000", zero_w, tc_w, evt_w);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_v [6];
      logic       exp_tc[6];
      logic       exp_ev[6];
      exp_v  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
      exp_tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      sel = 2'd1; lim_write_en = 1'b1; datain = 8'd5;
      tick();
      idle();
      inc = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (ch(dout_w, 1) !== exp_v[k] || tc_w[1] !== exp_tc[k] || evt_w[1] !== exp_ev[k]) begin
            n_fail++;
            $display("FAIL wrap_step%0d got v=%0d tc=%b evt=%b want v=%0d tc=%b evt=%b",
                     k, ch(dout_w, 1), tc_w[1], evt_w[1], exp_v[k], exp_tc[k], exp_ev[k]);
         end
      end
      idle();
      tick();
      n_checks++;
      if (evt_w !== 4'h0 || ch(dout_w, 1) !== 8'd0) begin
         n_fail++; $display("FAIL wrap_evt_one_cycle evt=%b v=%0d want 0000 v=0", evt_w, ch(dout_w, 1));
      end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_v [5];
      logic       exp_ev[5];
      exp_v  = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
      exp_ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      dec = 4'b0100;
      tick();
      idle();
      n_checks++;
      if (ch(dout_s, 2) !== 8'd0 || evt_s !== 4'b0100) begin
         n_fail++; $display("FAIL sat_dec_at_zero got v=%0d evt=%b want v=0 evt=0100", ch(dout_s, 2), evt_s);
      end
      tick();
      n_checks++;
      if (evt_s !== 4'b0000) begin
         n_fail++; $display("FAIL sat_evt_clear got %b want 0000", evt_s);
      end
      sel = 2'd2; lim_write_en = 1'b1; datain = 8'd3;
      tick();
      idle();
      inc = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (ch(dout_s, 2) !== exp_v[k] || evt_s[2] !== exp_ev[k]) begin
            n_fail++;
            $display("FAIL sat_inc_step%0d got v=%0d evt=%b want v=%0d evt=%b",
                     k, ch(dout_s, 2), evt_s[2], exp_v[k], exp_ev[k]);
         end
      end
      idle();
   endtask

   task automatic test_wrap_dec();
      do_reset();
      sel = 2'd0; lim_write_en = 1'b1; datain = 8'd9;
      tick();
      idle();
      dec = 4'b0001;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 0) !== 8'd9 || evt_w !== 4'b0001 || tc_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL wrap_dec_zero got v=%0d evt=%b tc=%b want v=9 evt=0001 tc=1", ch(dout_w, 0), evt_w, tc_w[0]);
      end
      n_checks++;
      if (ch(dout_s, 0) !== 8'd0 || evt_s !== 4'b0001) begin
         n_fail++; $display("FAIL sat_dec_zero9 got v=%0d evt=%b want v=0 evt=0001", ch(dout_s, 0), evt_s);
      end
   endtask

   task automatic test_priority();
      do_reset();
      clr = 4'b1000; sel = 2'd3; write_en = 1'b1; datain = 8'h44; inc = 4'b1000;
      tick();
      n_checks++;
      if (ch(dout_w, 3) !== 8'h00 || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL prio_clr got v=%h evt=%b want v=00 evt=0000", ch(dout_w, 3), evt_w);
      end
      clr = 4'b0000;
      tick();
      n_checks++;
      if (ch(dout_w, 3) !== 8'h44 || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL prio_load got v=%h evt=%b want v=44 evt=0000", ch(dout_w, 3), evt_w);
      end
      write_en = 1'b0; inc = 4'b1000; dec = 4'b1000;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 3) !== 8'h44 || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL prio_incdec_hold got v=%h evt=%b want v=44 evt=0000", ch(dout_w, 3), evt_w);
      end
      // Value and limit loaded together, then limit reload with inc uses old limit.
      sel = 2'd1; write_en = 1'b1; lim_write_en = 1'b1; datain = 8'd7;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 1) !== 8'd7 || tc_w[1] !== 1'b1 || ch(dout_w, 3) !== 8'h44) begin
         n_fail++; $display("FAIL dual_load got v=%0d tc=%b ch3=%h want v=7 tc=1 ch3=44", ch(dout_w, 1), tc_w[1], ch(dout_w, 3));
      end
      sel = 2'd1; lim_write_en = 1'b1; datain = 8'h20; inc = 4'b0010;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 1) !== 8'd0 || evt_w !== 4'b0010) begin
         n_fail++; $display("FAIL old_limit_wrap got v=%0d evt=%b want v=0 evt=0010", ch(dout_w, 1), evt_w);
      end
      inc = 4'b0010;
      for (int k = 0; k < 8; k++) tick();
      idle();
      n_checks++;
      if (ch(dout_w, 1) !== 8'd8 || tc_w[1] !== 1'b0 || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL new_limit_used got v=%0d tc=%b evt=%b want v=8 tc=0 evt=0000", ch(dout_w, 1), tc_w[1], evt_w);
      end
   endtask

   task automatic test_overlimit_and_reset();
      do_reset();
      sel = 2'd0; lim_write_en = 1'b1; datain = 8'h10;
      tick();
      lim_write_en = 1'b0; write_en = 1'b1; datain = 8'hF0;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 0) !== 8'hF0 || tc_w[0] !== 1'b1 || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL overlimit_load got v=%h tc=%b evt=%b want v=F0 tc=1 evt=0000", ch(dout_w, 0), tc_w[0], evt_w);
      end
      inc = 4'b0001;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 0) !== 8'h00 || evt_w !== 4'b0001) begin
         n_fail++; $display("FAIL overlimit_wrap got v=%h evt=%b want v=00 evt=0001", ch(dout_w, 0), evt_w);
      end
      n_checks++;
      if (ch(dout_s, 0) !== 8'hF0 || evt_s !== 4'b0001) begin
         n_fail++; $display("FAIL overlimit_sat got v=%h evt=%b want v=F0 evt=0001", ch(dout_s, 0), evt_s);
      end
      // Build some state, then reset with requests pending.
      inc = 4'b1110;
      tick(); tick();
      reset = 1'b1; sel = 2'd2; write_en = 1'b1; lim_write_en = 1'b1; datain = 8'h55; inc = 4'hF;
      tick();
      idle();
      n_checks++;
      if (dout_w !== 32'h0 || dout_s !== 32'h0 || evt_w !== 4'h0 || evt_s !== 4'h0 ||
          tc_w !== 4'h0 || zero_w !== 4'hF) begin
         n_fail++; $display("FAIL reset_mid got d=%h/%h evt=%b/%b tc=%b zero=%b want 0/0 0000 0000 1111",
                            dout_w, dout_s, evt_w, evt_s, tc_w, zero_w);
      end
      // Limit back to all-ones: FE is below it, FF reaches it.
      sel = 2'd2; write_en = 1'b1; datain = 8'hFE;
      tick();
      idle();
      n_checks++;
      if (tc_w[2] !== 1'b0) begin
         n_fail++; $display("FAIL reset_limit_fe got tc=%b want 0", tc_w[2]);
      end
      inc = 4'b0100;
      tick();
      idle();
      n_checks++;
      if (ch(dout_w, 2) !== 8'hFF || tc_w[2] !== 1'b1 || evt_w !== 4'h0) begin
         n_fail++; $display("FAIL reset_limit_ff got v=%h tc=%b evt=%b want v=FF tc=1 evt=0000", ch(dout_w, 2), tc_w[2], evt_w);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle();
      test_reset();
      test_inc();
      test_wrap();
      test_saturate();
      test_wrap_dec();
      test_priority();
      test_overlimit_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
